// File: rtl/des_dec_key_sched.sv
// DES decryption key schedule: presents the round subkeys K16 down to K1
// over a valid/ready handshake, starting from the PC-1 of the supplied key
// and rotating C and D right between rounds.
module des_dec_key_sched #(
  parameter bit PARITY_CHK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] key_in,
  input  logic        abort,
  input  logic        subkey_ready,
  output logic        subkey_valid,
  output logic [47:0] subkey,
  output logic [4:0]  round,
  output logic        busy,
  output logic        done,
  output logic        key_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_t;

  // Permuted choice tables, entries are 1-based DES bit numbers (bit 1 = MSB).
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1_f(input logic [63:0] k);
    logic [55:0] o;
    o = '0;
    for (int j = 0; j < 56; j++) o[55-j] = k[64-PC1_T[j]];
    return o;
  endfunction

  function automatic logic [47:0] pc2_f(input logic [55:0] cd);
    logic [47:0] o;
    o = '0;
    for (int j = 0; j < 48; j++) o[47-j] = cd[56-PC2_T[j]];
    return o;
  endfunction

  // Right rotation of a 28-bit half: bit i moves to i-1, bit 0 wraps to 27.
  function automatic logic [27:0] ror_f(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_t      state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [4:0]  round_q, round_d;
  logic        key_err_q, key_err_d;

  logic        parity_err;
  logic        single_shift;

  // A key byte is in error when it holds an even number of ones.
  always_comb begin
    parity_err = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (^key_in[8*b +: 8] == 1'b0) parity_err = 1'b1;
    end
  end

  assign single_shift = (round_q == 5'd1) || (round_q == 5'd2) ||
                        (round_q == 5'd9) || (round_q == 5'd16);

  // Next-state logic: accept start in IDLE, step rounds on each transfer.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d   = state_q;
    cd_d      = cd_q;
    round_d   = round_q;
    key_err_d = key_err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cd_d      = pc1_f(key_in);
          round_d   = 5'd16;
          key_err_d = PARITY_CHK ? parity_err : 1'b0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          round_d = 5'd0;
          state_d = S_IDLE;
        end else if (subkey_ready) begin
          if (round_q == 5'd1) begin
            round_d = 5'd0;
            state_d = S_DONE;
          end else begin
            cd_d    = {ror_f(cd_q[55:28], !single_shift),
                       ror_f(cd_q[27:0],  !single_shift)};
            round_d = round_q - 5'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset clearing the key state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cd_q      <= '0;
      round_q   <= '0;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cd_q      <= cd_d;
      round_q   <= round_d;
      key_err_q <= key_err_d;
    end
  end

  assign subkey_valid = (state_q == S_ISSUE);
  assign subkey       = subkey_valid ? pc2_f(cd_q) : 48'd0;
  assign round        = round_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign key_err      = PARITY_CHK ? key_err_q : 1'b0;

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Self-checking bench for des_dec_key_sched: a reference model builds the
// forward DES key schedule (left shifts, K1..K16) and the expected decryption
// order is queued; a monitor pops and compares on every handshake.
module tb_des_dec_key_sched;

  localparam logic [63:0] GOLD_KEY = 64'h133457799BBCDFF1;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, subkey_ready;
  logic [63:0] key_in;
  logic        subkey_valid, busy, done, key_err;
  logic [47:0] subkey;
  logic [4:0]  round;
  logic        np_valid, np_busy, np_done, np_key_err;
  logic [47:0] np_subkey;
  logic [4:0]  np_round;

  des_dec_key_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .abort(abort),
    .subkey_ready(subkey_ready), .subkey_valid(subkey_valid), .subkey(subkey),
    .round(round), .busy(busy), .done(done), .key_err(key_err)
  );

  des_dec_key_sched #(.PARITY_CHK(1'b0)) dut_np (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .abort(abort),
    .subkey_ready(subkey_ready), .subkey_valid(np_valid), .subkey(np_subkey),
    .round(np_round), .busy(np_busy), .done(np_done), .key_err(np_key_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic [47:0] ref_ks [1:16];

  // Forward FIPS schedule: C0D0 = PC1(key), rotate left per round, Ki = PC2.
  task automatic build_ref(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] k;
    for (int j = 1; j <= 56; j++) cd[56-j] = key[64-PC1_T[j-1]];
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 1; i <= 16; i++) begin
      for (int s = 0; s < SHIFTS[i-1]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 1; j <= 48; j++) k[48-j] = cd[56-PC2_T[j-1]];
      ref_ks[i] = k;
    end
  endtask

  function automatic logic parity_bad(input logic [63:0] key);
    int ones;
    for (int b = 0; b < 8; b++) begin
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(key[8*b+i]);
      if (ones % 2 == 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  // ---------------- scoreboard monitor ----------------
  typedef struct packed {
    logic [4:0]  rnd;
    logic [47:0] sk;
  } exp_t;

  exp_t        exp_q[$];
  int          done_cnt = 0;
  logic [47:0] last_sk;
  logic        prev_hold = 1'b0;
  logic [47:0] prev_sk;
  logic [4:0]  prev_rnd;

  // Compare presented subkeys on handshake cycles and check stalls hold.
  always @(negedge clk) begin
    exp_t e;
    if (prev_hold) begin
      check("stall_subkey", subkey, prev_sk);
      check("stall_round", round, prev_rnd);
      check("stall_valid", subkey_valid, 1'b1);
    end
    prev_hold = rst_n && !abort && subkey_valid && !subkey_ready;
    prev_sk   = subkey;
    prev_rnd  = round;
    if (rst_n && !abort && subkey_valid && subkey_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_subkey: got %h round %0d, none expected", subkey, round);
      end else begin
        e = exp_q.pop_front();
        check("subkey", subkey, e.sk);
        check("round", round, e.rnd);
        last_sk = subkey;
      end
    end
    if (!subkey_valid && subkey !== 48'd0) check("subkey_zero_when_invalid", subkey, 48'd0);
    if (done) done_cnt++;
  end

  // ---------------- stimulus ----------------
  logic [47:0] first_sk;
  int          done_cyc;

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, subkey_valid, 1'b0);
    check({tag, "_subkey"}, subkey, 48'd0);
    check({tag, "_round"}, round, 5'd0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  // Called at posedge+1 with the DUT idle.
  task automatic run_sched(input logic [63:0] key, input bit rnd_ready,
                           input int abort_at, input int rst_at, input bit poke);
    int  d0;
    int  cyc;
    bit  got_done;
    logic exp_err;
    build_ref(key);
    for (int r = 16; r >= 1; r--) exp_q.push_back({5'(r), ref_ks[r]});
    exp_err = parity_bad(key);
    start = 1'b1; key_in = key; abort = 1'b0; subkey_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; key_in = {$urandom, $urandom};
    first_sk = subkey;
    check("start_valid", subkey_valid, 1'b1);
    check("start_round", round, 5'd16);
    check("start_busy", busy, 1'b1);
    check("key_err", key_err, exp_err);
    check("key_err_nochk", np_key_err, 1'b0);
    d0 = done_cnt;
    got_done = 1'b0;
    cyc = 1;
    done_cyc = 0;
    for (int n = 0; n < 400 && !got_done; n++) begin
      if (abort_at != 0 && subkey_valid && round == 5'(abort_at)) begin
        abort = 1'b1; subkey_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        abort = 1'b0;
        check_all_zero("abort");
        exp_q.delete();
        repeat (20) @(posedge clk);
        #1 check("no_done_after_abort", done_cnt, d0);
        return;
      end
      if (rst_at != 0 && subkey_valid && round == 5'(rst_at)) begin
        rst_n = 1'b0; start = 1'b1; subkey_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_all_zero("reset");
        check("reset_key_err", key_err, 1'b0);
        rst_n = 1'b1;
        exp_q.delete();
        repeat (20) @(posedge clk);
        #1 check("no_done_after_reset", done_cnt, d0);
        return;
      end
      subkey_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      start = poke;
      key_in = {$urandom, $urandom};
      @(negedge clk);
      cyc++;
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        check("done_busy", busy, 1'b1);
        check("done_valid", subkey_valid, 1'b0);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("done_seen", got_done, 1'b1);
    check("idle_after_done_busy", busy, 1'b0);
    check("idle_after_done_valid", subkey_valid, 1'b0);
    check("all_subkeys_delivered", exp_q.size(), 0);
    check("single_done_pulse", done_cnt, d0 + 1);
    check("key_err_held", key_err, exp_err);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] k;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; subkey_ready = 1'b0; key_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("por");
    check("por_key_err", key_err, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Golden key, ready held high: timing and known first/last subkeys.
    run_sched(GOLD_KEY, 1'b0, 0, 0, 1'b0);
    check("gold_first", first_sk, 48'hCB3D8B0E17F5);
    check("gold_last", last_sk, 48'h1B02EFFC7072);
    check("gold_done_cycle", done_cyc, 18);

    // Same key with random back-pressure.
    run_sched(GOLD_KEY, 1'b1, 0, 0, 1'b0);
    check("rand_ready_last", last_sk, 48'h1B02EFFC7072);

    // All-zero key: zero subkeys and a parity error.
    run_sched(64'd0, 1'b0, 0, 0, 1'b0);

    // Abort at round 9, then a clean restart.
    run_sched(GOLD_KEY, 1'b0, 9, 0, 1'b0);
    run_sched(GOLD_KEY, 1'b0, 0, 0, 1'b0);
    check("restart_first", first_sk, 48'hCB3D8B0E17F5);

    // Start held high through ISSUE and DONE must be ignored.
    run_sched(GOLD_KEY, 1'b0, 0, 0, 1'b1);
    check("poke_done_cycle", done_cyc, 18);

    // Reset at round 5, then restart.
    run_sched(GOLD_KEY, 1'b0, 0, 5, 1'b0);
    run_sched(GOLD_KEY, 1'b0, 0, 0, 1'b0);
    check("after_reset_first", first_sk, 48'hCB3D8B0E17F5);

    // Random keys, with and without valid parity, under back-pressure.
    for (int t = 0; t < 4; t++) begin
      k = {$urandom, $urandom};
      if (t % 2 == 0) begin
        for (int b = 0; b < 8; b++) k[8*b] = ~^k[8*b+1 +: 7];
      end
      run_sched(k, 1'b1, 0, 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_dec_key_sched.md
DES_DEC_KEY_SCHED -- requirements
Module: des_dec_key_sched

Interface
REQ-001 SHALL provide parameter PARITY_CHK, default 1; when 1, key_err reports DES odd-parity violations, and when 0, key_err is tied 0.
REQ-002 SHALL provide clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL provide rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL provide start, input, 1 bit: request a new schedule; accepted only when busy=0.
REQ-005 SHALL provide key_in, input, 64 bits: DES key including parity bits; DES bit 1 = key_in[63].
REQ-006 SHALL provide abort, input, 1 bit: cancel the schedule in progress.
REQ-007 SHALL provide subkey_ready, input, 1 bit: consumer accepts the current subkey.
REQ-008 SHALL provide subkey_valid, output, 1 bit: subkey and round are valid.
REQ-009 SHALL provide subkey, output, 48 bits: round subkey after PC-2; DES bit 1 = subkey[47].
REQ-010 SHALL provide round, output, 5 bits: round number of the presented subkey, counting 16 down to 1.
REQ-011 SHALL provide busy, output, 1 bit: schedule in progress, including the DONE cycle.
REQ-012 SHALL provide done, output, 1 bit: one-cycle pulse after the K1 transfer.
REQ-013 SHALL provide key_err, output, 1 bit: at least one key byte had even parity at the last accepted start.

Function
REQ-014 SHALL hold a 56-bit CD register with C = CD[55:28] and D = CD[27:0]; PC-1 and PC-2 follow the FIPS 46-3 tables.
REQ-015 SHALL implement three states: IDLE, ISSUE and DONE.
REQ-016 SHALL, in IDLE on an edge with start=1, load CD <= PC1(key_in) and round <= 16, capture key_err, and enter ISSUE.
REQ-017 SHALL drive subkey = PC2(CD) and subkey_valid=1 throughout ISSUE; K16 therefore appears 1 cycle after start is sampled.
REQ-018 SHALL hold subkey, round and CD stable while subkey_valid=1 and subkey_ready=0.
REQ-019 SHALL, on a transfer (valid and ready) with round>1, rotate C and D each right by s(round) and decrement round.
REQ-020 SHALL define s(r) as 1 for r in {1, 2, 9, 16} and 2 otherwise.
REQ-021 SHALL define a right rotation as: bit i moves to bit i-1, and bit 0 wraps to bit 27.
REQ-022 SHALL, on a transfer with round=1, enter DONE; DONE asserts done=1, subkey_valid=0 and busy=1 for exactly 1 cycle, then returns to IDLE.
REQ-023 SHALL, with subkey_ready held at 1, deliver 16 subkeys (K16..K1) on 16 consecutive cycles, with done on cycle 18 counting the start edge as cycle 1.
REQ-024 SHALL ignore start whenever busy=1, including during DONE.
REQ-025 SHALL give abort priority over a transfer: the next edge goes to IDLE with subkey_valid=0, busy=0, round=0 and no done pulse.
REQ-026 SHALL ignore abort in IDLE.
REQ-027 SHALL, when start and abort arrive together in IDLE, accept start.
REQ-028 SHALL, when PARITY_CHK=1, set key_err=1 if any byte of key_in has an even number of ones.
REQ-029 SHALL hold key_err until the next accepted start; the schedule runs normally regardless of key_err.
REQ-030 SHALL drive subkey to 0 whenever subkey_valid=0.

Reset
REQ-031 SHALL, while rst_n=0 at a clock edge, force state=IDLE, CD=0, round=0, subkey_valid=0, subkey=0, busy=0, done=0 and key_err=0.
REQ-032 SHALL let reset override start, abort and any transfer, including mid-schedule.
REQ-033 SHALL produce no done pulse after a mid-schedule reset.

Verification
REQ-034 SHALL verify: key_in=0x133457799BBCDFF1 with ready=1 -> first subkey 0xCB3D8B0E17F5 with round=16; last subkey 0x1B02EFFC7072 with round=1; done on cycle 18; key_err=0.
REQ-035 SHALL verify: the same key, with ready toggled randomly -> subkey sequence identical to the ready=1 case, and subkey/round stable while ready=0.
REQ-036 SHALL verify: key_in=0 -> 16 subkeys, all 0x000000000000; key_err=1; PARITY_CHK=0 build gives key_err=0.
REQ-037 SHALL verify: abort asserted at round=9 -> next cycle subkey_valid=0, busy=0; no done; a following start restarts at K16.
REQ-038 SHALL verify: start pulsed during ISSUE and during DONE -> ignored, with the sequence unchanged.
REQ-039 SHALL verify: rst_n=0 at round=5 -> all outputs 0 on the next cycle; start then yields 0xCB3D8B0E17F5 after 1 cycle.
